// File: rtl/mem_loader.sv
// Burst loader: streams n words into BRAM port A from startaddr,
// keeping a running mod-2^DATA_W checksum and pulsing done at the end.
module mem_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              mclk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] startaddr,
    input  logic [CNT_W-1:0]  n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic              wea,
    output logic [CNT_W-1:0]  count,
    output logic [DATA_W-1:0] sum,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FINISH
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  len;
    logic [CNT_W:0]    count_inc;

    // One extra bit so a 2^CNT_W-1 word burst compares without overflow
    assign count_inc = {1'b0, count} + {{CNT_W{1'b0}}, 1'b1};

    always_ff @(posedge mclk) begin
        if (reset) begin
            state    <= IDLE;
            base     <= '0;
            len      <= '0;
            in_ready <= 1'b0;
            wea      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            addra    <= '0;
            dina     <= '0;
            count    <= '0;
            sum      <= '0;
        end else begin
            wea  <= 1'b0;
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        base  <= startaddr;
                        len   <= n;
                        count <= '0;
                        sum   <= '0;
                        busy  <= 1'b1;
                        if (n != '0) begin
                            state    <= LOAD;
                            in_ready <= 1'b1;
                        end else begin
                            state <= FINISH;
                        end
                    end
                end
                LOAD: begin
                    if (in_valid && in_ready) begin
                        wea   <= 1'b1;
                        addra <= base + ADDR_W'(count);
                        dina  <= in_data;
                        count <= count_inc[CNT_W-1:0];
                        sum   <= sum + in_data;
                        if (count_inc == {1'b0, len}) begin
                            in_ready <= 1'b0;
                            state    <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    in_ready <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Randomized bench for mem_loader against a queue-based model of the
// expected BRAM write sequence, checksum and done timing.
module tb_mem_loader;

    logic        mclk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  startaddr;
    logic [7:0]  n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [7:0]  addra;
    logic [15:0] dina;
    logic        wea;
    logic [7:0]  count;
    logic [15:0] sum;
    logic        busy;
    logic        done;

    mem_loader #(.ADDR_W(8), .DATA_W(16), .CNT_W(8)) dut (
        .mclk(mclk), .reset(reset), .start(start),
        .startaddr(startaddr), .n(n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .addra(addra), .dina(dina), .wea(wea),
        .count(count), .sum(sum), .busy(busy), .done(done)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_wea_cyc = 0;
    int          done_cyc = 0;
    int          done_seen = 0;
    bit          mon_en = 1'b0;
    wr_t         exp_q[$];
    wr_t         w;
    logic [15:0] wdata[256];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge mclk) cyc <= cyc + 1;

    // Every write must match the head of the expected write queue
    always @(negedge mclk) begin
        if (mon_en) begin
            if (wea) begin
                if (exp_q.size() == 0) begin
                    check("spurious_write", 32'd1, 32'd0);
                end else begin
                    w = exp_q.pop_front();
                    check("addra", {24'd0, addra}, {24'd0, w.a});
                    check("dina", {16'd0, dina}, {16'd0, w.d});
                end
                last_wea_cyc = cyc;
            end
            if (done) begin
                done_seen++;
                done_cyc = cyc;
            end
        end
    end

    // mode 0: valid always, 1: 2-cycle gap after word 2, 2: random stalls
    task automatic burst(input logic [7:0] a, input int len,
                         input int mode, input bit mid_start);
        int          i = 0;
        int          guard = 0;
        int          stalled = 0;
        int          s_cyc;
        logic [15:0] esum = '0;
        bit          v;
        bit          acc;
        for (int j = 0; j < len; j++) begin
            exp_q.push_back('{a: 8'(a + 8'(j)), d: wdata[j]});
            esum = esum + wdata[j];
        end
        done_seen = 0;
        start     = 1'b1;
        startaddr = a;
        n         = 8'(len);
        s_cyc     = cyc;
        @(posedge mclk); #1;
        start = 1'b0;
        check("busy_start", {31'd0, busy}, 32'd1);
        check("ready_start", {31'd0, in_ready}, {31'd0, len != 0});
        while (i < len && guard < 4 * len + 50) begin
            if (mode == 1 && i == 2 && stalled < 2) begin
                v = 1'b0;
                stalled++;
            end else if (mode == 2) begin
                v = ($urandom_range(0, 99) < 70);
            end else begin
                v = 1'b1;
            end
            in_valid = v;
            in_data  = v ? wdata[i] : 16'($urandom);
            if (mid_start && i == 1) begin
                start     = 1'b1;
                startaddr = 8'h80;
                n         = 8'd2;
            end else begin
                start = 1'b0;
            end
            acc = v && in_ready;
            @(posedge mclk); #1;
            if (acc) i++;
            guard++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (i < len) check("burst_timeout", i, len);
        repeat (3) @(posedge mclk);
        #1;
        check("done_pulses", done_seen, 32'd1);
        if (len == 0) begin
            check("done_n0", done_cyc, s_cyc + 2);
        end else begin
            check("done_cycle", done_cyc, s_cyc + guard + 2);
            check("done_after_wea", done_cyc, last_wea_cyc + 1);
        end
        check("count", {24'd0, count}, 32'(len));
        check("sum", {16'd0, sum}, {16'd0, esum});
        check("busy_end", {31'd0, busy}, 32'd0);
        check("ready_end", {31'd0, in_ready}, 32'd0);
        check("writes_left", exp_q.size(), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        startaddr = '0;
        n         = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        repeat (3) @(posedge mclk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (5) @(posedge mclk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_wea", {31'd0, wea}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_addra", {24'd0, addra}, 32'd0);
        check("rst_dina", {16'd0, dina}, 32'd0);
        check("rst_count", {24'd0, count}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);

        wdata[0] = 16'h0003;
        wdata[1] = 16'h0100;
        wdata[2] = 16'hFFFF;
        wdata[3] = 16'h0002;
        burst(8'h10, 4, 0, 1'b0);
        check("sum_basic", {16'd0, sum}, 32'h0104);
        burst(8'h10, 4, 1, 1'b0);
        check("sum_stall", {16'd0, sum}, 32'h0104);

        wdata[0] = 16'd1;
        wdata[1] = 16'd2;
        wdata[2] = 16'd3;
        burst(8'hFE, 3, 0, 1'b0);
        check("sum_wrap", {16'd0, sum}, 32'd6);

        burst(8'h33, 0, 0, 1'b0);
        for (int j = 0; j < 4; j++) wdata[j] = 16'($urandom);
        burst(8'h20, 4, 0, 1'b1);

        // Abort after two of five words
        for (int j = 0; j < 5; j++) wdata[j] = 16'($urandom);
        exp_q.push_back('{a: 8'h60, d: wdata[0]});
        exp_q.push_back('{a: 8'h61, d: wdata[1]});
        done_seen = 0;
        start     = 1'b1;
        startaddr = 8'h60;
        n         = 8'd5;
        @(posedge mclk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = wdata[0];
        @(posedge mclk); #1;
        in_data = wdata[1];
        @(posedge mclk); #1;
        in_data = wdata[2];
        reset   = 1'b1;
        @(posedge mclk); #1;
        check("abort_wea", {31'd0, wea}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_ready", {31'd0, in_ready}, 32'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (4) @(posedge mclk);
        #1;
        check("abort_no_done", done_seen, 32'd0);
        check("abort_writes", exp_q.size(), 32'd0);
        wdata[0] = 16'($urandom);
        burst(8'h40, 1, 0, 1'b0);

        for (int b = 0; b < 25; b++) begin
            for (int j = 0; j < 256; j++) wdata[j] = 16'($urandom);
            burst(8'($urandom), $urandom_range(1, 24), 2, b[0]);
        end
        for (int j = 0; j < 256; j++) wdata[j] = 16'($urandom);
        burst(8'($urandom), 255, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
